bk_multiword_addsub: RTL and testbench

- Sequential multi-precision add/subtract engine that streams operands one 32-bit limb per cycle, least-significant limb first, through the team's combinational 32-bit Brent-Kung adder (BrentKung32).
- Carries the inter-limb carry in a register, so an N-limb operation costs N accepted beats.
- Registers each sum limb with flags behind a valid/ready handshake.
- Sits between the operand source (register file or DMA) and the result consumer.

---
 rtl/bk_arith_pkg.sv | 30 +++
 rtl/bk_multiword_addsub_bk32.sv | 40 ++++
 rtl/bk_multiword_addsub.sv | 108 ++++++++++
 tb/tb_bk_multiword_addsub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bk_arith_pkg.sv
// Shared types and constants for the multi-word arithmetic engines.
// Limb width, FSM states and the registered limb result bundle.
package bk_arith_pkg;

   localparam int LIMB_W = 32;
   localparam int IDX_W  = 8;

   function automatic int ceil_log2(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++)
         if ((1 << k) < n) r = k + 1;
      return r;
   endfunction

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef struct packed {
      logic [LIMB_W-1:0] sum;
      logic [IDX_W-1:0]  idx;
      logic              last;
      logic              carry;
      logic              ovf;
      logic              zero;
   } limb_result_t;

endpackage

// File: rtl/bk_multiword_addsub_bk32.sv
// Combinational 32-bit Brent-Kung prefix adder (BrentKung32).
// Up-sweep builds power-of-two group terms, down-sweep fills the gaps.
module BrentKung32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] p;
   logic [31:0] gg;
   logic [31:0] pp;

   assign p = a ^ b;

   // gg[i] ends as the carry out of bit i, cin folded into bit 0
   always_comb begin
      gg = a & b;
      pp = a ^ b;
      gg[0] = gg[0] | (pp[0] & cin);
      for (int l = 0; l < 5; l++)
         for (int i = 0; i < 32; i++)
            if (((i + 1) % (2 << l)) == 0) begin
               gg[5'(i)] = gg[5'(i)]
                         | (pp[5'(i)] & gg[5'(i - (1 << l))]);
               pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << l))];
            end
      for (int l = 3; l >= 0; l--)
         for (int i = 0; i < 32; i++)
            if ((i >= 3 * (1 << l) - 1) &&
                (((i + 1 - (1 << l)) % (2 << l)) == 0))
               gg[5'(i)] = gg[5'(i)]
                         | (pp[5'(i)] & gg[5'(i - (1 << l))]);
   end

   assign sum  = p ^ {gg[30:0], cin};
   assign cout = gg[31];

endmodule

// File: rtl/bk_multiword_addsub.sv
// Multi-precision add/sub: one 32-bit limb per beat, LS limb first,
// carry chained through a register, results behind valid/ready.
module bk_multiword_addsub
   import bk_arith_pkg::*;
#(
   parameter int LIMBS = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic             mode_q;
   logic             zacc_q;
   logic             vld_q;
   limb_result_t     res_q;

   logic        accept;
   logic        first;
   logic        sub;
   logic        c0;
   logic        is_last;
   logic        cout;
   logic        sum_zero;
   logic        ovf;
   logic [31:0] op_b;
   logic [31:0] sum;

   assign in_ready = !vld_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign first    = (state == IDLE);
   assign sub      = first ? in_sub : mode_q;
   assign op_b     = in_b ^ {32{sub}};
   assign c0       = first ? (sub | in_cin) : carry_q;
   assign is_last  = (cnt == CNT_W'(LIMBS - 1));

   BrentKung32 u_adder (
      .a    (in_a),
      .b    (op_b),
      .cin  (c0),
      .sum  (sum),
      .cout (cout)
   );

   assign sum_zero = (sum == 32'd0);
   // carry into bit 31 xor carry out of bit 31
   assign ovf = in_a[31] ^ op_b[31] ^ sum[31] ^ cout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         carry_q <= 1'b0;
         mode_q  <= 1'b0;
         zacc_q  <= 1'b1;
         vld_q   <= 1'b0;
         res_q   <= '0;
      end else if (accept) begin
         vld_q       <= 1'b1;
         res_q.sum   <= sum;
         res_q.idx   <= IDX_W'(cnt);
         res_q.last  <= is_last;
         res_q.carry <= cout;
         res_q.ovf   <= is_last && ovf;
         res_q.zero  <= is_last && zacc_q && sum_zero;
         if (first) mode_q <= in_sub;
         if (is_last) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b1;
            state   <= IDLE;
         end else begin
            cnt     <= cnt + 1'b1;
            carry_q <= cout;
            zacc_q  <= zacc_q && sum_zero;
            state   <= BUSY;
         end
      end else if (out_ready) begin
         vld_q <= 1'b0;
      end
   end

   assign out_valid = vld_q;
   assign out_sum   = res_q.sum;
   assign out_idx   = CNT_W'(res_q.idx);
   assign out_last  = res_q.last;
   assign out_carry = res_q.carry;
   assign out_ovf   = res_q.ovf;
   assign out_zero  = res_q.zero;

endmodule

// File: tb/tb_bk_multiword_addsub.sv
// Bench for bk_multiword_addsub: directed and random 128-bit operations
// checked against a wide-integer reference model.
module tb_bk_multiword_addsub;

   localparam int LIMBS = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             in_sub;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_sum;
   logic [CNT_W-1:0] out_idx;
   logic             out_last;
   logic             out_carry;
   logic             out_ovf;
   logic             out_zero;

   int tests = 0;
   int fails = 0;

   logic [31:0] e_sum [LIMBS];
   logic        e_car [LIMBS];
   logic        e_ovf;
   logic        e_zero;

   bk_multiword_addsub #(.LIMBS(LIMBS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-operand arithmetic: per-limb results from truncated sums
   task automatic model(input logic [127:0] a, input logic [127:0] b,
                        input logic sub, input logic cin);
      logic [159:0] lo;
      logic [159:0] m;
      logic [127:0] b2;
      logic [127:0] r;
      logic         c0;
      b2 = sub ? ~b : b;
      c0 = sub ? 1'b1 : cin;
      for (int i = 0; i < LIMBS; i++) begin
         m  = (160'd1 << (32 * (i + 1))) - 160'd1;
         lo = ({32'd0, a} & m) + ({32'd0, b2} & m) + 160'(c0);
         e_sum[i] = lo[32*i +: 32];
         e_car[i] = lo[32*(i+1)];
      end
      r = sub ? (a - b) : (a + b + 128'(cin));
      if (sub)
         e_ovf = (a[127] != b[127]) && (r[127] != a[127]);
      else
         e_ovf = (a[127] == b[127]) && (r[127] != a[127]);
      e_zero = (r == 128'd0);
   endtask

   task automatic drive(input int i, input logic [127:0] a,
                        input logic [127:0] b, input logic sub,
                        input logic cin);
      in_a     = a[32*i +: 32];
      in_b     = b[32*i +: 32];
      in_sub   = (i == 0) ? sub : 1'($urandom);
      in_cin   = (i == 0) ? cin : 1'($urandom);
      in_valid = 1'b1;
   endtask

   task automatic chk_limb(input int i);
      logic lst;
      lst = (i == LIMBS - 1);
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_sum", 64'(out_sum), 64'(e_sum[i]));
      chk("out_idx", 64'(out_idx), 64'(i));
      chk("out_last", 64'(out_last), 64'(lst));
      chk("out_carry", 64'(out_carry), 64'(e_car[i]));
      chk("out_ovf", 64'(out_ovf), 64'(lst && e_ovf));
      chk("out_zero", 64'(out_zero), 64'(lst && e_zero));
   endtask

   task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                         input logic sub, input logic cin);
      model(a, b, sub, cin);
      for (int i = 0; i < LIMBS; i++) begin
         drive(i, a, b, sub, cin);
         chk("in_ready", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         chk_limb(i);
      end
   endtask

   logic [127:0] ra;
   logic [127:0] rb;
   logic [127:0] ones;

   initial begin
      ones      = '1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_flags", 64'({out_last, out_carry, out_ovf, out_zero}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 0, 0);
      chk("vec1_limb1", 64'(e_sum[1]), 64'd1);
      run_op({4{32'h1234_5678}}, {4{32'h1234_5678}}, 1, 0);
      run_op({32'h7FFF_FFFF, 96'd0}, {32'h0000_0001, 96'd0}, 0, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_valid", 64'(out_valid), 64'd0);

      // Stall after limb 1
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      model(ra, rb, 0, 1);
      drive(0, ra, rb, 0, 1);
      @(posedge clk);
      #1;
      chk_limb(0);
      drive(1, ra, rb, 0, 1);
      @(posedge clk);
      #1;
      chk_limb(1);
      out_ready = 1'b0;
      drive(2, ra, rb, 0, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
         chk_limb(1);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk_limb(2);
      drive(3, ra, rb, 0, 1);
      @(posedge clk);
      #1;
      chk_limb(3);

      // Abort mid-operation with the carry register set
      drive(0, ones, 128'd1, 0, 0);
      @(posedge clk);
      #1;
      drive(1, ones, 128'd1, 0, 0);
      @(posedge clk);
      #1;
      drive(2, ones, 128'd1, 0, 0);
      @(posedge clk);
      #1;
      chk("pre_abort_idx", 64'(out_idx), 64'd2);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_idx", 64'(out_idx), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op(128'd5, 128'd7, 0, 0);
      chk("abort_new_sum", 64'(e_sum[0]), 64'd12);

      // Back-to-back: add then sub, no bubble
      run_op(128'd0, 128'd0, 0, 1);
      run_op(128'd0, 128'd1, 1, 1);
      chk("b2b_final_carry", 64'(out_carry), 64'd0);
      chk("b2b_ms_sum", 64'(out_sum), 64'hFFFF_FFFF);

      for (int n = 0; n < 16; n++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = (n % 5 == 0) ? ra : {$urandom, $urandom, $urandom, $urandom};
         run_op(ra, rb, 1'($urandom), 1'($urandom));
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("end_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
